// File: rtl/aeolus_alu_pkg.sv
// aeolus_alu_pkg
//   Shared definitions for the ALU issue stage: default operand width,
//   opcode encoding and issue FSM state encoding.
package aeolus_alu_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } issue_state_e;

endpackage

// File: rtl/alu_logic_core.sv
// alu_logic_core
//   Purely combinational ALU datapath.
//   Ports:
//     A, B    : WIDTH-bit operands
//     OP      : opcode (AND / OR / XOR / ADD)
//     RESULT  : WIDTH-bit result
//     CARRY   : carry-out of ADD, 0 for the logic ops
module alu_logic_core
   import aeolus_alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  alu_op_e          OP,
   output logic [WIDTH-1:0] RESULT,
   output logic             CARRY
);

   logic [WIDTH:0] sum;

   // Add at WIDTH+1 bits so the top bit is the carry-out.
   assign sum = {1'b0, A} + {1'b0, B};

   always_comb begin
      RESULT = '0;
      CARRY  = 1'b0;
      case (OP)
         OP_AND: RESULT = A & B;
         OP_OR:  RESULT = A | B;
         OP_XOR: RESULT = A ^ B;
         OP_ADD: {CARRY, RESULT} = sum;
         default: begin
            RESULT = '0;
            CARRY  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-entry ALU issue stage with valid/ready handshakes on both sides.
//   A request is latched in IDLE, computed in EXEC and presented in DONE
//   until the downstream accepts it.
//   Ports:
//     CLK, RESET            : clock, asynchronous active-high reset
//     IN_VALID / IN_READY   : upstream handshake
//     IN_OP, IN_A, IN_B     : opcode and operands
//     OUT_VALID / OUT_READY : downstream handshake
//     OUT_RESULT, OUT_ZERO,
//     OUT_CARRY             : registered result and flags (held until next DONE)
//     OP_COUNT              : wrapping count of results handed downstream
module alu_issue_stage
   import aeolus_alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       IN_OP,
   input  logic [WIDTH-1:0] IN_A,
   input  logic [WIDTH-1:0] IN_B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_RESULT,
   output logic             OUT_ZERO,
   output logic             OUT_CARRY,
   output logic [CNT_W-1:0] OP_COUNT
);

   issue_state_e     state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   alu_op_e          op_code_q;
   logic [WIDTH-1:0] core_result;
   logic             core_carry;
   logic             accept, exec_en, handoff;

   alu_logic_core #(.WIDTH(WIDTH)) u_core (
      .A      (op_a_q),
      .B      (op_b_q),
      .OP     (op_code_q),
      .RESULT (core_result),
      .CARRY  (core_carry)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      accept    = 1'b0;
      exec_en   = 1'b0;
      handoff   = 1'b0;
      case (state_q)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec_en = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) begin
               handoff = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands are captured only at acceptance, so later input changes
   // cannot leak into the in-flight operation.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_code_q <= OP_AND;
      end else if (accept) begin
         op_a_q    <= IN_A;
         op_b_q    <= IN_B;
         op_code_q <= alu_op_e'(IN_OP);
      end
   end

   // Result registers update only in EXEC and otherwise retain the last
   // value; OUT_VALID is what qualifies them.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_RESULT <= '0;
         OUT_ZERO   <= 1'b0;
         OUT_CARRY  <= 1'b0;
      end else if (exec_en) begin
         OUT_RESULT <= core_result;
         OUT_ZERO   <= (core_result == '0);
         OUT_CARRY  <= core_carry;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)        OP_COUNT <= '0;
      else if (handoff) OP_COUNT <= OP_COUNT + 1'b1;
   end

endmodule
